// File: rtl/nanorisc_pkg.sv
// NanoRisc shared definitions: opcodes, ALU and PC-source codes,
// control FSM state encoding, opcode class bundle and ALU decoder.
package nanorisc_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_SUB   = 4'h1;
  localparam logic [3:0] OP_AND   = 4'h2;
  localparam logic [3:0] OP_OR    = 4'h3;
  localparam logic [3:0] OP_LOAD  = 4'h4;
  localparam logic [3:0] OP_STORE = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_JMP   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10
  } pc_src_e;

  // Nine states do not fit in three bits, so the register is four wide.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_WB     = 4'd3,
    S_ADDR   = 4'd4,
    S_MEM    = 4'd5,
    S_LWB    = 4'd6,
    S_BRANCH = 4'd7,
    S_HALTED = 4'd8
  } state_e;

  typedef struct packed {
    logic is_alu;
    logic is_mem;
    logic is_store;
    logic is_beq;
    logic is_jmp;
    logic is_halt;
    logic is_illegal;
  } op_class_t;

  // ALU-class opcodes 0..3 map straight onto the ALU codes.
  function automatic alu_op_e alu_dec(input logic [1:0] op);
    return alu_op_e'(op);
  endfunction

endpackage

// File: rtl/nanorisc_opdecode.sv
// NanoRisc opcode classifier (combinational).
// in: opcode[3:0]; out: one class flag per instruction group.
module nanorisc_opdecode
  import nanorisc_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_alu,
  output logic       is_mem,
  output logic       is_store,
  output logic       is_beq,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       is_illegal
);

  op_class_t c;

  always_comb begin
    c = '0;
    case (opcode)
      OP_ADD, OP_SUB,
      OP_AND, OP_OR:  c.is_alu = 1'b1;
      OP_LOAD:        c.is_mem = 1'b1;
      OP_STORE: begin
        c.is_mem   = 1'b1;
        c.is_store = 1'b1;
      end
      OP_BEQ:         c.is_beq  = 1'b1;
      OP_JMP:         c.is_jmp  = 1'b1;
      OP_HALT:        c.is_halt = 1'b1;
      default:        c.is_illegal = 1'b1;
    endcase
  end

  assign is_alu     = c.is_alu;
  assign is_mem     = c.is_mem;
  assign is_store   = c.is_store;
  assign is_beq     = c.is_beq;
  assign is_jmp     = c.is_jmp;
  assign is_halt    = c.is_halt;
  assign is_illegal = c.is_illegal;

endmodule

// File: rtl/nanorisc_control.sv
// NanoRisc multicycle control FSM: sequences fetch/decode/exec/mem/wb.
// in: clk, rst_n, run, opcode, zero, mem_ready
// out: memory handshake, datapath enables/selects, halted, error, retired.
module nanorisc_control
  import nanorisc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [1:0]       alu_op,
  output logic             alu_src_b,
  output logic             reg_write,
  output logic             wdata_sel,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  state_e state;
  state_e nxt;

  logic fetch_pend;
  logic retire;
  logic set_err;

  logic is_alu;
  logic is_mem;
  logic is_store;
  logic is_beq;
  logic is_jmp;
  logic is_halt;
  logic is_illegal;

  nanorisc_opdecode u_dec (
    .opcode     (opcode),
    .is_alu     (is_alu),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .is_beq     (is_beq),
    .is_jmp     (is_jmp),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  always_comb begin
    nxt          = state;
    retire       = 1'b0;
    set_err      = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_INC;
    alu_op       = ALU_ADD;
    alu_src_b    = 1'b0;
    reg_write    = 1'b0;
    wdata_sel    = 1'b0;

    unique case (state)
      S_FETCH: begin
        // A raised request is held by fetch_pend even if run drops.
        if (run || fetch_pend) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            pc_src   = PC_INC;
            nxt      = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_alu:  nxt = S_EXEC;
          is_mem:  nxt = S_ADDR;
          is_beq:  nxt = S_BRANCH;
          is_jmp: begin
            pc_write = 1'b1;
            pc_src   = PC_JMP;
            retire   = 1'b1;
            nxt      = S_FETCH;
          end
          is_halt: nxt = S_HALTED;
          default: begin
            set_err = 1'b1;
            nxt     = S_HALTED;
          end
        endcase
      end
      S_EXEC: begin
        alu_op = alu_dec(opcode[1:0]);
        nxt    = S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_ADDR: begin
        alu_op    = ALU_ADD;
        alu_src_b = 1'b1;
        nxt       = S_MEM;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_store;
        if (mem_ready) begin
          if (is_store) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt    = S_LWB;
          end
        end
      end
      S_LWB: begin
        reg_write = 1'b1;
        wdata_sel = 1'b1;
        retire    = 1'b1;
        nxt       = S_FETCH;
      end
      S_BRANCH: begin
        alu_op = ALU_SUB;
        if (zero) begin
          pc_write = 1'b1;
          pc_src   = PC_BR;
        end
        retire = 1'b1;
        nxt    = S_FETCH;
      end
      S_HALTED: nxt = S_HALTED;
      default:  nxt = S_FETCH;
    endcase

    // Reset kills every strobe at once, including an in-flight mem_req.
    if (!rst_n) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_INC;
      alu_op       = ALU_ADD;
      alu_src_b    = 1'b0;
      reg_write    = 1'b0;
      wdata_sel    = 1'b0;
      retire       = 1'b0;
      set_err      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      fetch_pend <= 1'b0;
      halted     <= 1'b0;
      error      <= 1'b0;
      retired    <= '0;
    end else begin
      state      <= nxt;
      fetch_pend <= (state == S_FETCH) && mem_req && !mem_ready;
      halted     <= (nxt == S_HALTED);
      if (set_err)
        error <= 1'b1;
      if (retire)
        retired <= retired + 1'b1;
    end
  end

endmodule
